// File: rtl/seg_scan_pkg.sv
// Shared types and default parameters for the seven-segment scan controller.
package seg_scan_pkg;

  // Slot phase: anodes dark (guard) or one digit lit (show).
  typedef enum logic {
    StGuard = 1'b0,
    StShow  = 1'b1
  } scan_state_e;

  localparam int unsigned DefDigits  = 4;
  localparam int unsigned DefTickDiv = 100000;
  localparam int unsigned DefGuard   = 1000;

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer: counts GUARD cycles, then TICK_DIV-GUARD show cycles, forever.
module seg_scan_timer
  import seg_scan_pkg::*;
#(
  parameter int unsigned TICK_DIV = DefTickDiv,
  parameter int unsigned GUARD    = DefGuard
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output scan_state_e state_o,
  output logic        guard_end_o,
  output logic        slot_end_o
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] GuardLast = CntW'(GUARD - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(TICK_DIV - GUARD - 1);

  scan_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Next-state: count within the phase, reload to zero on the phase's last cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    guard_end_o = 1'b0;
    slot_end_o  = 1'b0;
    unique case (state_q)
      StGuard: begin
        if (cnt_q == GuardLast) begin
          guard_end_o = 1'b1;
          state_d     = StShow;
          cnt_d       = '0;
        end
      end
      StShow: begin
        if (cnt_q == ShowLast) begin
          slot_end_o = 1'b1;
          state_d    = StGuard;
          cnt_d      = '0;
        end
      end
      default: begin
        state_d = StGuard;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StGuard;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered display value.
// The frame boundary is the last show cycle of the final digit, so a committed
// value is already on dec_val_o throughout the guard that precedes digit 0.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned DIGITS   = DefDigits,
  parameter int unsigned TICK_DIV = DefTickDiv,
  parameter int unsigned GUARD    = DefGuard
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [4*DIGITS-1:0]   wr_data_i,
  input  logic [DIGITS-1:0]     wr_blank_i,
  output logic [3:0]            dec_val_o,
  input  logic [6:0]            dec_seg_i,
  output logic [6:0]            seg_o,
  output logic [DIGITS-1:0]     an_n_o,
  output logic                  frame_done_o
);

  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  scan_state_e state;
  logic        guard_end;
  logic        slot_end;

  logic [4*DIGITS-1:0] act_val_q, act_val_d;
  logic [DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                pend_full_q, pend_full_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0]   an_n_q, an_n_d;
  logic [6:0]          seg_q;

  logic wr_fire;
  logic boundary;
  logic show_next;

  seg_scan_timer #(
    .TICK_DIV (TICK_DIV),
    .GUARD    (GUARD)
  ) u_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .state_o     (state),
    .guard_end_o (guard_end),
    .slot_end_o  (slot_end)
  );

  assign wr_fire   = wr_valid_i & ~pend_full_q;
  assign boundary  = slot_end & (idx_q == LastIdx);
  // Anode register is loaded with the phase of the coming cycle so it tracks state.
  assign show_next = guard_end | ((state == StShow) & ~slot_end);

  // Buffer handshake, commit at the frame boundary, digit index and anode next-state.
  always_comb begin
    act_val_d    = act_val_q;
    act_blank_d  = act_blank_q;
    pend_val_d   = pend_val_q;
    pend_blank_d = pend_blank_q;
    pend_full_d  = pend_full_q;
    idx_d        = idx_q;
    an_n_d       = '1;

    // wr_fire requires pend_full_q low, so it never coincides with a commit.
    if (boundary && pend_full_q) begin
      act_val_d   = pend_val_q;
      act_blank_d = pend_blank_q;
      pend_full_d = 1'b0;
    end else if (wr_fire) begin
      pend_val_d   = wr_data_i;
      pend_blank_d = wr_blank_i;
      pend_full_d  = 1'b1;
    end

    if (slot_end) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
    end

    if (show_next && !act_blank_q[idx_q]) begin
      an_n_d[idx_q] = 1'b0;
    end
  end

  // Digit select for the shared decoder.
  always_comb begin
    dec_val_o = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        dec_val_o = act_val_q[4*i +: 4];
      end
    end
  end

  // Buffers, index and registered pin drives.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_val_q    <= '0;
      act_blank_q  <= '1;
      pend_val_q   <= '0;
      pend_blank_q <= '1;
      pend_full_q  <= 1'b0;
      idx_q        <= '0;
      an_n_q       <= '1;
      seg_q        <= '0;
    end else begin
      act_val_q    <= act_val_d;
      act_blank_q  <= act_blank_d;
      pend_val_q   <= pend_val_d;
      pend_blank_q <= pend_blank_d;
      pend_full_q  <= pend_full_d;
      idx_q        <= idx_d;
      an_n_q       <= an_n_d;
      seg_q        <= dec_seg_i;
    end
  end

  assign wr_ready_o   = ~pend_full_q;
  assign an_n_o       = an_n_q;
  assign seg_o        = seg_q;
  assign frame_done_o = boundary;

endmodule
